debouncer_bank: RTL and testbench
=================================

# debouncer_bank

Multi-channel, parametrised switch/button debouncer for the bomb detonator front panel and any other mechanical inputs. Each channel synchronises its raw input through two flops, then requires a configurable number of stable sample ticks before its debounced output changes. On every accepted change, the channel also emits a one-cycle rise or fall pulse, so downstream FSMs do not need their own edge detectors. All channels share one clock, one reset and one sample-tick strobe.

## Interface
Parameters:
- CHANNELS, 4 — number of independent input channels (≥1).
- STABLE_CYCLES, 256 — consecutive stable ticks required before an output changes (≥1).
- RST_VAL, 1'b0 — reset value of every synchroniser flop and debounced output.
- CNT_W, $clog2(STABLE_CYCLES+1) — per-channel counter width (derived, do not override).

Ports:
- clk  in  1  — system clock; all state updates on its rising edge.
- rst  in  1  — asynchronous, active-high reset.
- tick  in  1  — sample-enable strobe (tie to 1 for per-clock counting).
- in  in  CHANNELS  — raw asynchronous inputs.
- out  out  CHANNELS  — debounced levels.
- rise  out  CHANNELS  — one-cycle pulse when out[i] goes 0→1.
- fall  out  CHANNELS  — one-cycle pulse when out[i] goes 1→0.
- any_edge  out  1  — OR-reduction of rise|fall.

## Operation
- Each channel i is fully independent. Its state is s1[i], s2[i], cnt[i] (CNT_W bits) and out[i].
- Every clock: s1 ← in[i] and s2 ← s1.
- Counter rules, in priority order:
  - If s1 ≠ s2: cnt ← 0. This applies regardless of tick.
  - Else, if tick = 1 and cnt < STABLE_CYCLES: cnt ← cnt+1.
  - Else: cnt holds.
- The counter saturates at STABLE_CYCLES and never wraps.
- Output update: if cnt == STABLE_CYCLES and s2 ≠ out[i], then out[i] ← s2. Otherwise out[i] holds.
- rise[i] and fall[i] are registered. In the same edge that out[i] changes:
  - rise[i] ← (s2 & ~out[i]) and fall[i] ← (~s2 & out[i]).
  - Both are 0 on every other edge.
- rise[i] and fall[i] are never high together.
- any_edge is combinational from the registered rise/fall.
- A new input transition arriving while the counter is saturated clears cnt. The old out value is kept until the new level has been stable for STABLE_CYCLES ticks.
- A glitch shorter than STABLE_CYCLES ticks never reaches out, regardless of how often it repeats.

## Timing
Reset:
- Asserting rst forces, immediately and asynchronously: s1 = s2 = out = {CHANNELS{RST_VAL}}, cnt = 0, rise = fall = 0, any_edge = 0.
- Deasserting rst mid-count discards all progress. Counting restarts from 0 on the first clock after release.

Latency, with tick = 1 and N = STABLE_CYCLES. Input changes before edge 0 and then stays stable:
- Edge 0: s1 = new.
- Edge 1: s2 = new; cnt ← 0, because s1 ≠ s2 before this edge.
- Edge 1+k: cnt = k.
- Edge N+1: cnt = N.
- Edge N+2: out = new; rise or fall is high for the single cycle following edge N+2.
- Total latency is N+2 clocks from the first sampling edge.

Latency with a sparse tick:
- cnt advances only on edges where tick = 1.
- out changes on the first edge at which cnt == N is observed. That edge need not have tick = 1.

Other rules:
- In the steady state (input equal to out), cnt sits at N and nothing toggles.
- Immediately after reset, cnt counts up to N. No pulse is generated because s2 == out.
- A simultaneous input change on several channels produces pulses on the same cycle on each channel.

## Test plan
- Reset/idle: hold rst = 1, then release with in = 4'b0000, N = 4, tick = 1 → out = 0000, rise = fall = 0 for 20 cycles.
- Clean press: N = 4, in[0] 0→1 before edge 0 and held → out[0] = 1 after edge 6, rise[0] = 1 for exactly one cycle, any_edge = 1 that cycle, other channels unchanged.
- Bounce rejection: toggle in[1] every 3 clocks for 40 clocks with N = 4, then hold at 1 → no change on out[1] during bouncing; out[1] = 1 exactly 6 edges after the last toggle; a single rise[1] pulse.
- Release and fall: from out[2] = 1, drive in[2] = 0 and hold → fall[2] pulses once at latency N+2 and rise[2] stays 0; repeat with N = 1 → latency 3.
- Tick prescale: tick = 1 every 4th clock, N = 4, in[3] rises → out[3] changes within 2 + 4×4 clocks (±3 clocks for tick phase); a glitch of 2 clocks between ticks is rejected.
- Reset mid-operation: start a press on in[0] with N = 8, assert rst at cnt = 5 for one clock, keep in[0] = 1 → out[0] = RST_VAL immediately; out[0] = 1 at N+2 edges after release; one rise pulse only.

Source files
------------

// File: rtl/debouncer_bank.sv
// debouncer_bank: per-channel two-flop synchroniser and stable-tick counter
// with registered one-cycle rise/fall pulses.
module debouncer_bank #(
    parameter int   CHANNELS      = 4,
    parameter int   STABLE_CYCLES = 256,
    parameter logic RST_VAL       = 1'b0,
    parameter int   CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                any_edge
);
    localparam logic [CNT_W-1:0] MAX = CNT_W'(STABLE_CYCLES);

    logic [CHANNELS-1:0] s1_q, s2_q, out_q, out_d, rise_q, rise_d, fall_q, fall_d;
    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_d [CHANNELS];

    // A level change between the synchroniser stages restarts the count even without a tick.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i]  = (s1_q[i] != s2_q[i]) ? '0 :
                        (tick && cnt_q[i] < MAX) ? cnt_q[i] + 1'b1 : cnt_q[i];
            rise_d[i] = (cnt_q[i] == MAX) && s2_q[i] && !out_q[i];
            fall_d[i] = (cnt_q[i] == MAX) && !s2_q[i] && out_q[i];
            out_d[i]  = (rise_d[i] || fall_d[i]) ? s2_q[i] : out_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= {CHANNELS{RST_VAL}};
            s2_q   <= {CHANNELS{RST_VAL}};
            out_q  <= {CHANNELS{RST_VAL}};
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
        end else begin
            s1_q   <= in;
            s2_q   <= s1_q;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign out      = out_q;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign any_edge = |(rise_q | fall_q);
endmodule

// File: tb/tb_debouncer_bank.sv
// tb_debouncer_bank: three debouncer banks (N = 4, 1, 8) driven in parallel and
// compared every cycle against a tick-timestamp reference model.
module tb_debouncer_bank;
    localparam int NS [3] = '{4, 1, 8};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] din = '0;
    logic [3:0] o [3];
    logic [3:0] r [3];
    logic [3:0] f [3];
    logic       a [3];

    int checks = 0;
    int errors = 0;

    // Model: a channel's synchronised level may reach out once the number of
    // ticks seen since that level last changed is at least N.
    logic [3:0] ms1, ms2;
    logic [3:0] mo [3];
    logic [3:0] mr [3];
    logic [3:0] mf [3];
    int         tot = 0;
    int         chg [4];

    always #5 clk = ~clk;

    debouncer_bank #(.CHANNELS(4), .STABLE_CYCLES(4)) dut0 (
        .clk(clk), .rst(rst), .tick(tick), .in(din),
        .out(o[0]), .rise(r[0]), .fall(f[0]), .any_edge(a[0]));
    debouncer_bank #(.CHANNELS(4), .STABLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .tick(tick), .in(din),
        .out(o[1]), .rise(r[1]), .fall(f[1]), .any_edge(a[1]));
    debouncer_bank #(.CHANNELS(4), .STABLE_CYCLES(8)) dut2 (
        .clk(clk), .rst(rst), .tick(tick), .in(din),
        .out(o[2]), .rise(r[2]), .fall(f[2]), .any_edge(a[2]));

    task automatic model_reset();
        ms1 = '0;
        ms2 = '0;
        for (int k = 0; k < 3; k++) begin
            mo[k] = '0;
            mr[k] = '0;
            mf[k] = '0;
        end
        for (int c = 0; c < 4; c++) chg[c] = tot;
    endtask

    task automatic model_edge();
        int pre;
        if (rst) return;
        pre = tot;
        tot += int'(tick);
        for (int k = 0; k < 3; k++)
            for (int c = 0; c < 4; c++) begin
                mr[k][c] = 1'b0;
                mf[k][c] = 1'b0;
                if (pre - chg[c] >= NS[k] && ms2[c] != mo[k][c]) begin
                    mr[k][c] = ms2[c];
                    mf[k][c] = !ms2[c];
                    mo[k][c] = ms2[c];
                end
            end
        for (int c = 0; c < 4; c++) if (ms1[c] != ms2[c]) chg[c] = tot;
        ms2 = ms1;
        ms1 = din;
    endtask

    task automatic step(input logic t, input logic [3:0] v);
        tick = t;
        din  = v;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 4'b0000);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 4'b0000);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if ({o[k], r[k], f[k], a[k]} !== {mo[k], mr[k], mf[k], |(mr[k] | mf[k])}) begin
                    errors++;
                    $display("FAIL reset_idle dut%0d step%0d: got %b want %b", k, i,
                             {o[k], r[k], f[k], a[k]}, {mo[k], mr[k], mf[k], |(mr[k] | mf[k])});
                end
            end
        end
        checks++;
        if ({o[0], r[0], f[0]} !== 12'h000) begin
            errors++;
            $display("FAIL reset_idle_const: got %h want 000", {o[0], r[0], f[0]});
        end
    endtask

    task automatic test_clean_press();
        int at [3];
        int n [3];
        for (int k = 0; k < 3; k++) begin at[k] = -1; n[k] = 0; end
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 4'b0001);
            for (int k = 0; k < 3; k++) begin
                if (r[k][0]) begin n[k]++; if (at[k] < 0) at[k] = i; end
                checks++;
                if ({o[k], r[k], f[k], a[k]} !== {mo[k], mr[k], mf[k], |(mr[k] | mf[k])}) begin
                    errors++;
                    $display("FAIL press dut%0d step%0d: got %b want %b", k, i,
                             {o[k], r[k], f[k], a[k]}, {mo[k], mr[k], mf[k], |(mr[k] | mf[k])});
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (at[k] != NS[k] + 2 || n[k] != 1 || o[k] !== 4'b0001) begin
                errors++;
                $display("FAIL press_latency dut%0d: rise at %0d x%0d out %b, want at %0d x1 out 0001",
                         k, at[k], n[k], o[k], NS[k] + 2);
            end
        end
    endtask

    task automatic test_bounce();
        int at [3];
        int n [3];
        logic [3:0] v;
        for (int k = 0; k < 3; k++) begin at[k] = -1; n[k] = 0; end
        for (int i = 0; i < 54; i++) begin
            v = din;
            v[1] = (i >= 40) ? 1'b1 : ((i / 3) % 2 == 0);
            step(1'b1, v);
            for (int k = 0; k < 3; k++) begin
                if (r[k][1]) begin n[k]++; if (at[k] < 0) at[k] = i - 40; end
                checks++;
                if ({o[k], r[k], f[k], a[k]} !== {mo[k], mr[k], mf[k], |(mr[k] | mf[k])}) begin
                    errors++;
                    $display("FAIL bounce dut%0d step%0d: got %b want %b", k, i,
                             {o[k], r[k], f[k], a[k]}, {mo[k], mr[k], mf[k], |(mr[k] | mf[k])});
                end
            end
            checks++;
            if (i < 40 && (o[0][1] !== 1'b0 || o[2][1] !== 1'b0)) begin
                errors++;
                $display("FAIL bounce_leak step%0d: got %b/%b want 0/0", i, o[0][1], o[2][1]);
            end
        end
        for (int k = 0; k < 3; k += 2) begin
            checks++;
            if (at[k] != NS[k] + 2 || n[k] != 1) begin
                errors++;
                $display("FAIL bounce_settle dut%0d: rise at %0d x%0d, want at %0d x1", k, at[k], n[k], NS[k] + 2);
            end
        end
    endtask

    task automatic test_release();
        int at [3];
        int n [3];
        int nr [3];
        logic [3:0] v;
        for (int k = 0; k < 3; k++) begin at[k] = -1; n[k] = 0; nr[k] = 0; end
        for (int i = 0; i < 28; i++) begin
            v = din;
            v[2] = (i < 14);
            step(1'b1, v);
            for (int k = 0; k < 3; k++) begin
                if (i >= 14 && f[k][2]) begin n[k]++; if (at[k] < 0) at[k] = i - 14; end
                if (i >= 14 && r[k][2]) nr[k]++;
                checks++;
                if ({o[k], r[k], f[k], a[k]} !== {mo[k], mr[k], mf[k], |(mr[k] | mf[k])}) begin
                    errors++;
                    $display("FAIL release dut%0d step%0d: got %b want %b", k, i,
                             {o[k], r[k], f[k], a[k]}, {mo[k], mr[k], mf[k], |(mr[k] | mf[k])});
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (at[k] != NS[k] + 2 || n[k] != 1 || nr[k] != 0) begin
                errors++;
                $display("FAIL release_latency dut%0d: fall at %0d x%0d rise x%0d, want at %0d x1 rise x0",
                         k, at[k], n[k], nr[k], NS[k] + 2);
            end
        end
    endtask

    task automatic test_prescale();
        int at = -1;
        logic [3:0] v;
        for (int i = 0; i < 80; i++) begin
            v = din;
            v[3] = !(i == 49 || i == 50);
            step(i % 4 == 0, v);
            if (r[0][3] && at < 0) at = i;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if ({o[k], r[k], f[k], a[k]} !== {mo[k], mr[k], mf[k], |(mr[k] | mf[k])}) begin
                    errors++;
                    $display("FAIL prescale dut%0d step%0d: got %b want %b", k, i,
                             {o[k], r[k], f[k], a[k]}, {mo[k], mr[k], mf[k], |(mr[k] | mf[k])});
                end
            end
            checks++;
            if (i >= 48 && (o[0][3] !== 1'b1 || o[2][3] !== 1'b1)) begin
                errors++;
                $display("FAIL prescale_glitch step%0d: got %b/%b want 1/1", i, o[0][3], o[2][3]);
            end
        end
        checks++;
        if (at < 15 || at > 21) begin
            errors++;
            $display("FAIL prescale_latency: rise at %0d, want 15..21", at);
        end
    endtask

    task automatic test_reset_mid();
        int at = -1;
        int n = 0;
        rst = 1'b1;
        model_reset();
        step(1'b1, 4'b0000);
        rst = 1'b0;
        for (int i = 0; i < 14; i++) step(1'b1, 4'b0000);
        for (int i = 0; i < 7; i++) step(1'b1, 4'b0001);
        rst = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({o[k], r[k], f[k], a[k]} !== 13'd0) begin
                errors++;
                $display("FAIL reset_async dut%0d: got %b want 0", k, {o[k], r[k], f[k], a[k]});
            end
        end
        step(1'b1, 4'b0001);
        rst = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 4'b0001);
            if (r[2][0]) begin n++; if (at < 0) at = i; end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if ({o[k], r[k], f[k], a[k]} !== {mo[k], mr[k], mf[k], |(mr[k] | mf[k])}) begin
                    errors++;
                    $display("FAIL reset_mid dut%0d step%0d: got %b want %b", k, i,
                             {o[k], r[k], f[k], a[k]}, {mo[k], mr[k], mf[k], |(mr[k] | mf[k])});
                end
            end
        end
        checks++;
        if (at != NS[2] + 2 || n != 1) begin
            errors++;
            $display("FAIL reset_mid_latency: rise at %0d x%0d, want at %0d x1", at, n, NS[2] + 2);
        end
    endtask

    task automatic test_random();
        int hold [4];
        logic [3:0] v;
        for (int c = 0; c < 4; c++) hold[c] = 0;
        v = din;
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < 4; c++) begin
                if (hold[c] == 0) begin
                    v[c] = 1'($urandom_range(0, 1));
                    hold[c] = int'($urandom_range(1, 12));
                end
                hold[c]--;
            end
            step($urandom_range(0, 3) != 0, v);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if ({o[k], r[k], f[k], a[k]} !== {mo[k], mr[k], mf[k], |(mr[k] | mf[k])}) begin
                    errors++;
                    $display("FAIL random dut%0d step%0d: got %b want %b", k, i,
                             {o[k], r[k], f[k], a[k]}, {mo[k], mr[k], mf[k], |(mr[k] | mf[k])});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_prescale();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
